// File: rtl/rnic_axil_cfg_master_if.sv
// AXI4-Lite bus bundle between the ERNIC configuration master and the ERNIC
// s_axi_lite_* register slave port.
//   master modport : drives AW/W/AR address, data, valids and B/R readies.
//   slave modport  : drives AW/W/AR readies and the B/R response channels.
// Parameters: ADDR_W (address width), DATA_W (data width, 32 or 64).
interface rnic_axil_cfg_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_axi_lite_awaddr;
  logic                s_axi_lite_awvalid;
  logic                s_axi_lite_awready;
  logic [DATA_W-1:0]   s_axi_lite_wdata;
  logic [DATA_W/8-1:0] s_axi_lite_wstrb;
  logic                s_axi_lite_wvalid;
  logic                s_axi_lite_wready;
  logic [1:0]          s_axi_lite_bresp;
  logic                s_axi_lite_bvalid;
  logic                s_axi_lite_bready;
  logic [ADDR_W-1:0]   s_axi_lite_araddr;
  logic                s_axi_lite_arvalid;
  logic                s_axi_lite_arready;
  logic [DATA_W-1:0]   s_axi_lite_rdata;
  logic [1:0]          s_axi_lite_rresp;
  logic                s_axi_lite_rvalid;
  logic                s_axi_lite_rready;

  modport master (
    output s_axi_lite_awaddr, s_axi_lite_awvalid, s_axi_lite_wdata, s_axi_lite_wstrb,
           s_axi_lite_wvalid, s_axi_lite_bready, s_axi_lite_araddr, s_axi_lite_arvalid,
           s_axi_lite_rready,
    input  s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bresp, s_axi_lite_bvalid,
           s_axi_lite_arready, s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid
  );

  modport slave (
    input  s_axi_lite_awaddr, s_axi_lite_awvalid, s_axi_lite_wdata, s_axi_lite_wstrb,
           s_axi_lite_wvalid, s_axi_lite_bready, s_axi_lite_araddr, s_axi_lite_arvalid,
           s_axi_lite_rready,
    output s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bresp, s_axi_lite_bvalid,
           s_axi_lite_arready, s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid
  );
endinterface

// File: rtl/rnic_axil_cfg_master.sv
// Single-outstanding AXI4-Lite write master for the ERNIC register-config
// sequencer. One start pulse = one AXI4-Lite write, optionally followed by a
// read-back and compare of the same address. Keeps sticky error flags and
// saturating counters for bring-up debug.
//
// Optional feature macro: RNIC_AXIL_TIMEOUT_EN -- per-request watchdog of
// C_TIMEOUT cycles. Without it the master waits indefinitely for the slave.
//
// Ports:
//   s_axi_lite_aclk   clock, rising edge
//   s_axi_lite_rst    synchronous active-high reset
//   i_gen_txns        start pulse, sampled only when idle
//   i_addr / i_data   request address / write data, captured with the start
//   axil              AXI4-Lite master bus (interface, master modport)
//   o_txns_done       one-cycle pulse when a request completes
//   o_busy            high from accept through the done cycle
//   o_resp_err        sticky: non-OKAY bresp/rresp (or watchdog expiry)
//   o_rdbk_mismatch   sticky: read-back data differed from written data
//   o_wr_cnt          completed OKAY writes, saturating
//   o_err_cnt         error events (responses + mismatches), saturating
module rnic_axil_cfg_master #(
  parameter int C_S_AXI_LITE_ADDR_WIDTH = 32,
  parameter int C_S_AXI_LITE_DATA_WIDTH = 32,
  parameter int C_READ_BCK_REG          = 0,
  parameter int C_TIMEOUT               = 1024
) (
  input  logic                               s_axi_lite_aclk,
  input  logic                               s_axi_lite_rst,
  input  logic                               i_gen_txns,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0] i_addr,
  input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0] i_data,
  rnic_axil_cfg_master_if.master             axil,
  output logic                               o_txns_done,
  output logic                               o_busy,
  output logic                               o_resp_err,
  output logic                               o_rdbk_mismatch,
  output logic [15:0]                        o_wr_cnt,
  output logic [15:0]                        o_err_cnt
);
  localparam int AW = C_S_AXI_LITE_ADDR_WIDTH;
  localparam int DW = C_S_AXI_LITE_DATA_WIDTH;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [2:0]    state;
  logic [AW-1:0] awaddr_q;
  logic [AW-1:0] araddr_q;
  logic [DW-1:0] wdata_q;
  logic          awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic          bresp_ok;
  logic          tmo_hit;

  assign axil.s_axi_lite_awaddr  = awaddr_q;
  assign axil.s_axi_lite_awvalid = awvalid_q;
  assign axil.s_axi_lite_wdata   = wdata_q;
  assign axil.s_axi_lite_wstrb   = '1;
  assign axil.s_axi_lite_wvalid  = wvalid_q;
  assign axil.s_axi_lite_bready  = bready_q;
  assign axil.s_axi_lite_araddr  = araddr_q;
  assign axil.s_axi_lite_arvalid = arvalid_q;
  assign axil.s_axi_lite_rready  = rready_q;

  // A channel counts as finished once its valid has dropped or is being
  // accepted this cycle, so AW and W may complete in either order.
  logic aw_ok, w_ok;
  assign aw_ok = !awvalid_q || axil.s_axi_lite_awready;
  assign w_ok  = !wvalid_q  || axil.s_axi_lite_wready;

  // Response and data mismatch are separate error events on the same beat.
  logic       rresp_bad, rd_mm;
  logic [1:0] rd_err_inc;
  always_comb begin
    rresp_bad  = (axil.s_axi_lite_rresp != 2'b00);
    rd_mm      = (axil.s_axi_lite_rdata != wdata_q);
    rd_err_inc = {1'b0, rresp_bad} + {1'b0, rd_mm};
  end

`ifdef RNIC_AXIL_TIMEOUT_EN
  localparam int TMO_W = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_cnt;
  assign tmo_hit = (tmo_cnt == TMO_W'(C_TIMEOUT - 1));

  // Counts edges since accept; holds at the limit so a late entry into a
  // response-wait state expires immediately.
  always_ff @(posedge s_axi_lite_aclk) begin
    if (s_axi_lite_rst || state == S_IDLE) begin
      tmo_cnt <= '0;
    end else if (state != S_DONE && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge s_axi_lite_aclk) begin
    if (s_axi_lite_rst) begin
      state           <= S_IDLE;
      awaddr_q        <= '0;
      araddr_q        <= '0;
      wdata_q         <= '0;
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      bready_q        <= 1'b0;
      arvalid_q       <= 1'b0;
      rready_q        <= 1'b0;
      bresp_ok        <= 1'b0;
      o_txns_done     <= 1'b0;
      o_busy          <= 1'b0;
      o_resp_err      <= 1'b0;
      o_rdbk_mismatch <= 1'b0;
      o_wr_cnt        <= '0;
      o_err_cnt       <= '0;
    end else begin
      o_txns_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_gen_txns) begin
            awaddr_q  <= i_addr;
            wdata_q   <= i_data;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bresp_ok  <= 1'b0;
            o_busy    <= 1'b1;
            state     <= S_WR;
          end
        end
        S_WR: begin
          if (awvalid_q && axil.s_axi_lite_awready) awvalid_q <= 1'b0;
          if (wvalid_q && axil.s_axi_lite_wready)   wvalid_q  <= 1'b0;
          // Valids stay up past the watchdog; only the flag is raised.
          if (tmo_hit) o_resp_err <= 1'b1;
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state    <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (axil.s_axi_lite_bvalid) begin
            bready_q <= 1'b0;
            if (axil.s_axi_lite_bresp != 2'b00) begin
              o_resp_err <= 1'b1;
              o_err_cnt  <= sat_add16(o_err_cnt, 2'd1);
            end else begin
              bresp_ok <= 1'b1;
            end
            if (C_READ_BCK_REG != 0) begin
              araddr_q  <= awaddr_q;
              arvalid_q <= 1'b1;
              state     <= S_RD_ADDR;
            end else begin
              o_txns_done <= 1'b1;
              state       <= S_DONE;
            end
          end else if (tmo_hit) begin
            bready_q    <= 1'b0;
            o_resp_err  <= 1'b1;
            o_err_cnt   <= sat_add16(o_err_cnt, 2'd1);
            o_txns_done <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (tmo_hit) o_resp_err <= 1'b1;
          if (axil.s_axi_lite_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axil.s_axi_lite_rvalid) begin
            rready_q <= 1'b0;
            if (rresp_bad) o_resp_err      <= 1'b1;
            if (rd_mm)     o_rdbk_mismatch <= 1'b1;
            o_err_cnt   <= sat_add16(o_err_cnt, rd_err_inc);
            o_txns_done <= 1'b1;
            state       <= S_DONE;
          end else if (tmo_hit) begin
            rready_q    <= 1'b0;
            o_resp_err  <= 1'b1;
            o_err_cnt   <= sat_add16(o_err_cnt, 2'd1);
            o_txns_done <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bresp_ok) o_wr_cnt <= sat_add16(o_wr_cnt, 2'd1);
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rnic_axil_cfg_master.sv
// Bench for rnic_axil_cfg_master. Lane 0 is a write-only master, lane 1 a
// read-back master; each lane has its own behavioural AXI4-Lite slave with
// programmable AW/W ready delays, response codes and read-data corruption.
module tb_rnic_axil_cfg_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        gen[2];
  logic [31:0] addr_in, data_in;

  // Slave behaviour knobs, shared by both lanes.
  int          aw_dly, w_dly;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rxor;
  logic        b_block;

  logic        done_o[2], busy_o[2], re_o[2], mm_o[2];
  logic [15:0] wrc_o[2], errc_o[2];
  logic        awv_o[2], wv_o[2], brd_o[2], arv_o[2], rrd_o[2];
  logic [31:0] awa_o[2], wd_o[2], ara_o[2];
  logic [3:0]  ws_o[2];
  int          n_aw_a[2], n_b_a[2], n_done_a[2], n_awcyc_a[2], n_wcyc_a[2];
  logic [31:0] c_awaddr_a[2], c_wdata_a[2], c_araddr_a[2];

  for (genvar g = 0; g < 2; g++) begin : lane
    rnic_axil_cfg_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    rnic_axil_cfg_master #(
      .C_S_AXI_LITE_ADDR_WIDTH(32),
      .C_S_AXI_LITE_DATA_WIDTH(32),
      .C_READ_BCK_REG(g),
      .C_TIMEOUT(16)
    ) dut (
      .s_axi_lite_aclk(clk),
      .s_axi_lite_rst (rst),
      .i_gen_txns     (gen[g]),
      .i_addr         (addr_in),
      .i_data         (data_in),
      .axil           (bus),
      .o_txns_done    (done_o[g]),
      .o_busy         (busy_o[g]),
      .o_resp_err     (re_o[g]),
      .o_rdbk_mismatch(mm_o[g]),
      .o_wr_cnt       (wrc_o[g]),
      .o_err_cnt      (errc_o[g])
    );

    int          aw_wait, w_wait;
    logic        aw_got, w_got, b_pend, bv, rv;
    logic [31:0] rd;
    int          n_aw = 0, n_b = 0, n_done = 0, n_awcyc = 0, n_wcyc = 0;
    logic [31:0] c_awaddr = '0, c_wdata = '0, c_araddr = '0;
    logic        aw_hs, w_hs, ar_hs, both_now;

    assign bus.s_axi_lite_awready = bus.s_axi_lite_awvalid && (aw_wait >= aw_dly);
    assign bus.s_axi_lite_wready  = bus.s_axi_lite_wvalid  && (w_wait >= w_dly);
    assign bus.s_axi_lite_bvalid  = bv;
    assign bus.s_axi_lite_bresp   = bresp_cfg;
    assign bus.s_axi_lite_arready = bus.s_axi_lite_arvalid;
    assign bus.s_axi_lite_rvalid  = rv;
    assign bus.s_axi_lite_rdata   = rd;
    assign bus.s_axi_lite_rresp   = rresp_cfg;

    assign aw_hs    = bus.s_axi_lite_awvalid && bus.s_axi_lite_awready;
    assign w_hs     = bus.s_axi_lite_wvalid && bus.s_axi_lite_wready;
    assign ar_hs    = bus.s_axi_lite_arvalid && bus.s_axi_lite_arready;
    assign both_now = (aw_got || aw_hs) && (w_got || w_hs);

    always @(posedge clk) begin
      if (aw_hs) begin n_aw <= n_aw + 1; c_awaddr <= bus.s_axi_lite_awaddr; end
      if (w_hs) c_wdata <= bus.s_axi_lite_wdata;
      if (ar_hs) c_araddr <= bus.s_axi_lite_araddr;
      if (bus.s_axi_lite_awvalid) n_awcyc <= n_awcyc + 1;
      if (bus.s_axi_lite_wvalid) n_wcyc <= n_wcyc + 1;
      if (bv && bus.s_axi_lite_bready) n_b <= n_b + 1;
      if (done_o[g]) n_done <= n_done + 1;
      if (rst) begin
        aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
        b_pend <= 1'b0; bv <= 1'b0; rv <= 1'b0; rd <= '0;
      end else begin
        aw_wait <= aw_hs ? 0 : (bus.s_axi_lite_awvalid ? aw_wait + 1 : aw_wait);
        w_wait  <= w_hs ? 0 : (bus.s_axi_lite_wvalid ? w_wait + 1 : w_wait);
        if (both_now) begin
          aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
          if (aw_hs) aw_got <= 1'b1;
          if (w_hs) w_got <= 1'b1;
        end
        if (bv && bus.s_axi_lite_bready) bv <= 1'b0;
        else if (!bv && !b_block && (both_now || b_pend)) begin bv <= 1'b1; b_pend <= 1'b0; end
        else if (both_now) b_pend <= 1'b1;
        if (ar_hs) begin rv <= 1'b1; rd <= c_wdata ^ rxor; end
        else if (rv && bus.s_axi_lite_rready) rv <= 1'b0;
      end
    end

    assign awv_o[g] = bus.s_axi_lite_awvalid;
    assign wv_o[g]  = bus.s_axi_lite_wvalid;
    assign brd_o[g] = bus.s_axi_lite_bready;
    assign arv_o[g] = bus.s_axi_lite_arvalid;
    assign rrd_o[g] = bus.s_axi_lite_rready;
    assign awa_o[g] = bus.s_axi_lite_awaddr;
    assign wd_o[g]  = bus.s_axi_lite_wdata;
    assign ara_o[g] = bus.s_axi_lite_araddr;
    assign ws_o[g]  = bus.s_axi_lite_wstrb;
    assign n_aw_a[g]    = n_aw;
    assign n_b_a[g]     = n_b;
    assign n_done_a[g]  = n_done;
    assign n_awcyc_a[g] = n_awcyc;
    assign n_wcyc_a[g]  = n_wcyc;
    assign c_awaddr_a[g] = c_awaddr;
    assign c_wdata_a[g]  = c_wdata;
    assign c_araddr_a[g] = c_araddr;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Start one request on a lane and return the number of edges from the
  // accepting edge until the done pulse is visible (-1 if it never came).
  task automatic run_txn(input int ln, input logic [31:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    addr_in = a; data_in = d; gen[ln] = 1'b1;
    @(posedge clk); #1;
    gen[ln] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (done_o[ln]) begin lat = k; break; end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    int ln; logic [31:0] addr, data; int awd, wd;
    logic [1:0] bresp, rresp; logic [31:0] rx;
    int lat, wr_inc, err_inc; logic mm, re; int awcyc, wcyc;
  } vec_t;

  typedef struct {
    int ln, lat; logic [15:0] wr, err; logic re, mm; int awcyc, wcyc; logic [31:0] addr, data;
  } exp_t;

  vec_t        vecs[8];
  exp_t        sb[$];
  logic [15:0] mdl_wr[2], mdl_err[2];
  logic        mdl_re[2], mdl_mm[2];

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    int   lat, aw0, b0, d0, awc0, wc0;

    //          ln addr          data          awd wd bresp  rresp  rx            lat wr er mm    re    awc wc
    vecs[0] = '{0, 32'h0002_0000, 32'h1234_5678, 0, 0, 2'b00, 2'b00, 32'h0,        2, 1, 0, 1'b0, 1'b0, 1, 1};
    vecs[1] = '{0, 32'h0002_0004, 32'hDEAD_BEEF, 3, 0, 2'b00, 2'b00, 32'h0,        5, 1, 0, 1'b0, 1'b0, 4, 1};
    vecs[2] = '{0, 32'h0000_0010, 32'hA5A5_A5A5, 0, 2, 2'b00, 2'b00, 32'h0,        4, 1, 0, 1'b0, 1'b0, 1, 3};
    vecs[3] = '{1, 32'h0002_0000, 32'h1234_5678, 0, 0, 2'b00, 2'b00, 32'h1,        4, 1, 1, 1'b1, 1'b0, 1, 1};
    vecs[4] = '{1, 32'h0000_0020, 32'h0000_0000, 0, 0, 2'b00, 2'b00, 32'h0,        4, 1, 0, 1'b0, 1'b0, 1, 1};
    vecs[5] = '{0, 32'h0000_0030, 32'h0000_0001, 0, 0, 2'b10, 2'b00, 32'h0,        2, 0, 1, 1'b0, 1'b1, 1, 1};
    vecs[6] = '{1, 32'h0000_0040, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b11, 32'h8000_0000, 4, 1, 2, 1'b1, 1'b1, 1, 1};
    vecs[7] = '{1, 32'h0000_0044, 32'h0000_0055, 2, 1, 2'b00, 2'b00, 32'h0,        6, 1, 0, 1'b0, 1'b0, 3, 2};

    gen[0] = 1'b0; gen[1] = 1'b0; addr_in = '0; data_in = '0;
    aw_dly = 0; w_dly = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00; rxor = '0; b_block = 1'b0;
    for (int l = 0; l < 2; l++) begin
      mdl_wr[l] = '0; mdl_err[l] = '0; mdl_re[l] = 1'b0; mdl_mm[l] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      chk("rst_valids", {awv_o[l], wv_o[l], brd_o[l], arv_o[l], rrd_o[l]}, 0);
      chk("rst_awaddr", awa_o[l], 0);
      chk("rst_wdata", wd_o[l], 0);
      chk("rst_araddr", ara_o[l], 0);
      chk("rst_wstrb", ws_o[l], 4'hF);
      chk("rst_status", {done_o[l], busy_o[l], re_o[l], mm_o[l]}, 0);
      chk("rst_counters", {wrc_o[l], errc_o[l]}, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      aw_dly = v.awd; w_dly = v.wd; bresp_cfg = v.bresp; rresp_cfg = v.rresp; rxor = v.rx;
      mdl_wr[v.ln]  = mdl_wr[v.ln] + 16'(v.wr_inc);
      mdl_err[v.ln] = mdl_err[v.ln] + 16'(v.err_inc);
      mdl_re[v.ln]  = mdl_re[v.ln] | v.re;
      mdl_mm[v.ln]  = mdl_mm[v.ln] | v.mm;
      e = '{v.ln, v.lat, mdl_wr[v.ln], mdl_err[v.ln], mdl_re[v.ln], mdl_mm[v.ln],
            v.awcyc, v.wcyc, v.addr, v.data};
      sb.push_back(e);
      aw0 = n_aw_a[v.ln]; b0 = n_b_a[v.ln]; d0 = n_done_a[v.ln];
      awc0 = n_awcyc_a[v.ln]; wc0 = n_wcyc_a[v.ln];
      run_txn(v.ln, v.addr, v.data, lat);
      e = sb.pop_front();
      chk($sformatf("v%0d_latency", i), lat, e.lat);
      chk($sformatf("v%0d_wr_cnt", i), wrc_o[e.ln], e.wr);
      chk($sformatf("v%0d_err_cnt", i), errc_o[e.ln], e.err);
      chk($sformatf("v%0d_resp_err", i), re_o[e.ln], e.re);
      chk($sformatf("v%0d_mismatch", i), mm_o[e.ln], e.mm);
      chk($sformatf("v%0d_aw_count", i), n_aw_a[e.ln] - aw0, 1);
      chk($sformatf("v%0d_b_count", i), n_b_a[e.ln] - b0, 1);
      chk($sformatf("v%0d_done_count", i), n_done_a[e.ln] - d0, 1);
      chk($sformatf("v%0d_awvalid_cycles", i), n_awcyc_a[e.ln] - awc0, e.awcyc);
      chk($sformatf("v%0d_wvalid_cycles", i), n_wcyc_a[e.ln] - wc0, e.wcyc);
      chk($sformatf("v%0d_awaddr", i), c_awaddr_a[e.ln], e.addr);
      chk($sformatf("v%0d_wdata", i), c_wdata_a[e.ln], e.data);
      if (e.ln == 1) chk($sformatf("v%0d_araddr", i), c_araddr_a[e.ln], e.addr);
      chk($sformatf("v%0d_busy_after", i), busy_o[e.ln], 0);
    end

    // Second start while waiting for B must be dropped.
    aw_dly = 0; w_dly = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00; rxor = '0; b_block = 1'b1;
    aw0 = n_aw_a[0]; b0 = n_b_a[0]; d0 = n_done_a[0];
    @(negedge clk);
    addr_in = 32'h0000_0050; data_in = 32'h0BAD_F00D; gen[0] = 1'b1;
    @(negedge clk);
    gen[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("dup_busy_in_wr_resp", {busy_o[0], brd_o[0]}, 2'b11);
    addr_in = 32'h0000_0060; gen[0] = 1'b1;
    @(negedge clk);
    gen[0] = 1'b0;
    b_block = 1'b0;
    repeat (12) @(negedge clk);
    mdl_wr[0] = mdl_wr[0] + 16'd1;
    chk("dup_aw_count", n_aw_a[0] - aw0, 1);
    chk("dup_b_count", n_b_a[0] - b0, 1);
    chk("dup_done_count", n_done_a[0] - d0, 1);
    chk("dup_awaddr", c_awaddr_a[0], 32'h0000_0050);
    chk("dup_wr_cnt", wrc_o[0], mdl_wr[0]);
    chk("dup_busy_after", busy_o[0], 0);

`ifdef RNIC_AXIL_TIMEOUT_EN
    // B never arrives: watchdog closes the request after 16 cycles.
    b_block = 1'b1;
    run_txn(0, 32'h0000_0070, 32'h0000_0077, lat);
    mdl_err[0] = mdl_err[0] + 16'd1;
    chk("tmo_latency", lat, 16);
    chk("tmo_resp_err", re_o[0], 1);
    chk("tmo_err_cnt", errc_o[0], mdl_err[0]);
    chk("tmo_wr_cnt", wrc_o[0], mdl_wr[0]);
    chk("tmo_bready_low", brd_o[0], 0);
`endif

    // Reset in the middle of WR.
    aw_dly = 10; w_dly = 10;
    @(negedge clk);
    addr_in = 32'h0000_0080; data_in = 32'h0000_0088; gen[0] = 1'b1;
    @(negedge clk);
    gen[0] = 1'b0;
    @(negedge clk);
    chk("rstmid_pre_valids", {awv_o[0], wv_o[0], busy_o[0]}, 3'b111);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_valids", {awv_o[0], wv_o[0], brd_o[0]}, 0);
    chk("rstmid_busy", busy_o[0], 0);
    chk("rstmid_counters", {wrc_o[0], errc_o[0], re_o[0]}, 0);
    @(negedge clk);
    rst = 1'b0; b_block = 1'b0; aw_dly = 0; w_dly = 0;
    run_txn(0, 32'h0000_0090, 32'hCAFE_0001, lat);
    chk("rstmid_recover_latency", lat, 2);
    chk("rstmid_recover_wr_cnt", wrc_o[0], 1);
    chk("rstmid_recover_wdata", c_wdata_a[0], 32'hCAFE_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
